// File: rtl/arb_mux.sv
// Registered N:1 channel mux with valid/ready handshakes.
// Fixed mode selects the channel named by select_i; round-robin mode grants
// the first valid channel at or after a rotating pointer.
module arb_mux #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mode_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic [NUM_CH-1:0]       valid_i,
    input  logic [NUM_CH*WIDTH-1:0] data_i,
    output logic [NUM_CH-1:0]       ready_o,
    output logic                    valid_o,
    output logic [WIDTH-1:0]        data_o,
    output logic [SEL_W-1:0]        grant_o,
    input  logic                    ready_i
);

    logic              valid_q;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SEL_W-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              valid_d;

    logic              load;
    logic              has_win;
    logic [SEL_W-1:0]  win_sel;
    logic [WIDTH-1:0]  win_data;
    logic              xfer;
    int                rr_idx;

    assign load = !valid_q || ready_i;

    // Winner selection: fixed index (out-of-range never wins) or RR scan from ptr.
    always_comb begin
        has_win = 1'b0;
        win_sel = '0;
        rr_idx  = 0;
        if (!mode_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(select_i) == k && valid_i[k]) begin
                    has_win = 1'b1;
                    win_sel = SEL_W'(k);
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                rr_idx = int'(ptr_q) + i;
                if (rr_idx >= NUM_CH) begin
                    rr_idx = rr_idx - NUM_CH;
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!has_win && k == rr_idx && valid_i[k]) begin
                        has_win = 1'b1;
                        win_sel = SEL_W'(k);
                    end
                end
            end
        end
    end

    // Data of the winning channel and the one-hot accept vector.
    always_comb begin
        win_data = '0;
        ready_o  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(win_sel) == k) begin
                win_data   = data_i[k*WIDTH +: WIDTH];
                ready_o[k] = load && !rst_i && has_win;
            end
        end
    end

    assign xfer = load && has_win && !rst_i;

    // Next-state for the output register and the round-robin pointer.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            valid_d = 1'b1;
            data_d  = win_data;
            grant_d = win_sel;
            if (mode_i) begin
                ptr_d = (int'(win_sel) == NUM_CH - 1) ? '0 : SEL_W'(int'(win_sel) + 1);
            end
        end else if (load) begin
            // Slot drained with nothing new: drop valid, keep last data/grant.
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a held beat is discarded on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed vector bench for arb_mux (NUM_CH=3, WIDTH=32).
module tb_arb_mux;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned SEL_W  = 2;

    logic                    clk;
    logic                    rst;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_CH-1:0]       vin;
    logic [NUM_CH*WIDTH-1:0] din;
    logic [NUM_CH-1:0]       rdy_o;
    logic                    vout;
    logic [WIDTH-1:0]        dout;
    logic [SEL_W-1:0]        gout;
    logic                    rdy_i;

    arb_mux #(
        .WIDTH (WIDTH),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .mode_i  (mode),
        .select_i(sel),
        .valid_i (vin),
        .data_i  (din),
        .ready_o (rdy_o),
        .valid_o (vout),
        .data_o  (dout),
        .grant_o (gout),
        .ready_i (rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [2:0]  valid;
        logic        rdy;
        logic [2:0]  exp_rdy;
        logic        exp_v;
        logic [31:0] exp_d;
        logic [1:0]  exp_g;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic m, input logic [1:0] s,
                       input logic [2:0] v, input logic rd, input logic [2:0] er,
                       input logic ev, input logic [31:0] ed, input logic [1:0] eg);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.rdy = rd;
        t.exp_rdy = er; t.exp_v = ev; t.exp_d = ed; t.exp_g = eg;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive one step: inputs after negedge, check ready_o, then registered outputs.
    task automatic step(input int idx, input logic r, input logic m, input logic [1:0] s,
                        input logic [2:0] v, input logic rd, input logic [2:0] er,
                        input logic ev, input logic [31:0] ed, input logic [1:0] eg);
        @(negedge clk);
        rst = r; mode = m; sel = s; vin = v; rdy_i = rd;
        #1;
        n_vec++;
        chk("ready_o", idx, 32'(rdy_o), 32'(er));
        @(posedge clk);
        #1;
        chk("valid_o", idx, 32'(vout), 32'(ev));
        chk("data_o", idx, dout, ed);
        chk("grant_o", idx, 32'(gout), 32'(eg));
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; vin = '0; rdy_i = 1'b1;
        din = {32'hC, 32'hB, 32'hA};

        //   rst mode sel valid rdy | exp_rdy v data   grant
        add(1, 0, 0, 3'b111, 1, 3'b000, 0, 32'h0, 0);  // reset state
        add(0, 0, 1, 3'b111, 1, 3'b010, 1, 32'hB, 1);  // fixed select 1
        add(0, 0, 1, 3'b111, 1, 3'b010, 1, 32'hB, 1);
        add(0, 0, 3, 3'b111, 1, 3'b000, 0, 32'hB, 1);  // out-of-range select
        add(0, 0, 3, 3'b111, 1, 3'b000, 0, 32'hB, 1);
        add(1, 0, 0, 3'b111, 1, 3'b000, 0, 32'h0, 0);  // reset before RR
        add(0, 1, 0, 3'b111, 1, 3'b001, 1, 32'hA, 0);  // RR 0,1,2,0,1,2
        add(0, 1, 0, 3'b111, 1, 3'b010, 1, 32'hB, 1);
        add(0, 1, 0, 3'b111, 1, 3'b100, 1, 32'hC, 2);
        add(0, 1, 0, 3'b111, 1, 3'b001, 1, 32'hA, 0);
        add(0, 1, 0, 3'b111, 1, 3'b010, 1, 32'hB, 1);
        add(0, 1, 0, 3'b111, 1, 3'b100, 1, 32'hC, 2);
        add(0, 1, 0, 3'b111, 1, 3'b001, 1, 32'hA, 0);  // ptr -> 1
        add(0, 1, 0, 3'b111, 0, 3'b000, 1, 32'hA, 0);  // stall x4
        add(0, 1, 0, 3'b111, 0, 3'b000, 1, 32'hA, 0);
        add(0, 1, 0, 3'b111, 0, 3'b000, 1, 32'hA, 0);
        add(0, 1, 0, 3'b111, 0, 3'b000, 1, 32'hA, 0);
        add(0, 1, 0, 3'b111, 1, 3'b010, 1, 32'hB, 1);  // release, ptr -> 2
        add(0, 1, 0, 3'b100, 1, 3'b100, 1, 32'hC, 2);  // ptr -> 0
        add(0, 1, 0, 3'b001, 1, 3'b001, 1, 32'hA, 0);  // ptr -> 1
        add(0, 1, 0, 3'b101, 1, 3'b100, 1, 32'hC, 2);  // ptr=1, 101 -> ch2
        add(0, 1, 0, 3'b101, 1, 3'b001, 1, 32'hA, 0);  // then ch0, ptr -> 1
        add(0, 0, 2, 3'b111, 1, 3'b100, 1, 32'hC, 2);  // fixed, ptr kept at 1
        add(0, 1, 0, 3'b111, 1, 3'b010, 1, 32'hB, 1);  // RR resumes at 1
        add(0, 1, 0, 3'b000, 1, 3'b000, 0, 32'hB, 1);  // no valid: drain
        add(0, 1, 0, 3'b111, 1, 3'b100, 1, 32'hC, 2);  // ptr -> 0
        add(0, 1, 0, 3'b111, 1, 3'b001, 1, 32'hA, 0);  // ptr -> 1
        add(1, 1, 0, 3'b111, 0, 3'b000, 0, 32'h0, 0);  // reset with beat held
        add(0, 1, 0, 3'b111, 1, 3'b001, 1, 32'hA, 0);  // ptr restarted at 0

        for (int i = 0; i < vecs.size(); i++) begin
            step(i, vecs[i].rst, vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].rdy,
                 vecs[i].exp_rdy, vecs[i].exp_v, vecs[i].exp_d, vecs[i].exp_g);
        end

        // Held beat is immune to input data changes during a stall; ptr now 1.
        din[0 +: WIDTH] = 32'h55;
        for (int i = 0; i < 3; i++) begin
            step(100 + i, 0, 1, 0, 3'b001, 0, 3'b000, 1, 32'hA, 0);
        end
        step(103, 0, 1, 0, 3'b001, 1, 3'b001, 1, 32'h55, 0);  // ch0 wins from ptr 1
        step(104, 0, 1, 0, 3'b000, 1, 3'b000, 0, 32'h55, 0);
        // Stall while empty must still load (load = !valid_o).
        step(105, 0, 0, 1, 3'b010, 0, 3'b010, 1, 32'hB, 1);
        step(106, 0, 0, 1, 3'b010, 0, 3'b000, 1, 32'hB, 1);
        step(107, 0, 0, 0, 3'b010, 1, 3'b000, 0, 32'hB, 1);   // sel 0 not valid

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
